// File: rtl/one_hot_pkg.sv
// Shared definitions for the one-hot encoder slice: width derivation and the
// two-state output-register control encoding.
package one_hot_pkg;

    // Output register occupancy: EMPTY means no result is held.
    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } ctrl_state_e;

    // One-hot vector width needed to cover every index of a binary_width index.
    function automatic int unsigned one_hot_width(input int unsigned binary_width);
        return 32'd1 << binary_width;
    endfunction

endpackage

// File: rtl/one_hot_priority_enc.sv
// Combinational lowest-set-bit encoder with zero-hot and multi-hot flags.
// Kept free of handshake logic so arbiters can reuse it directly.
module one_hot_priority_enc
    import one_hot_pkg::*;
#(
    parameter int unsigned BINARY_WIDTH = 2,
    localparam int unsigned ONE_HOT_WIDTH = one_hot_width(BINARY_WIDTH)
) (
    input  logic [ONE_HOT_WIDTH-1:0] one_hot_in,
    output logic [BINARY_WIDTH-1:0]  index,
    output logic                     zero,
    output logic                     multi
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        for (int i = ONE_HOT_WIDTH - 1; i >= 0; i--) begin
            if (one_hot_in[i]) begin
                index = BINARY_WIDTH'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something behind only if two or more were set.
    always_comb begin
        zero  = (one_hot_in == '0);
        multi = ((one_hot_in & (one_hot_in - ONE_HOT_WIDTH'(1))) != '0);
    end

endmodule

// File: rtl/one_hot_encoder.sv
// Registered one-hot to binary encoder on a valid/ready handshake. Illegal
// codes (zero-hot, multi-hot) are flagged per result and tallied in a
// saturating counter that is independent of output backpressure.
module one_hot_encoder
    import one_hot_pkg::*;
#(
    parameter int unsigned BINARY_WIDTH  = 2,
    parameter int unsigned ERR_CNT_WIDTH = 8,
    localparam int unsigned ONE_HOT_WIDTH = one_hot_width(BINARY_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ONE_HOT_WIDTH-1:0] one_hot_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BINARY_WIDTH-1:0]  binary_out,
    output logic                     out_err,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    input  logic                     clear_err
);

    localparam logic [ERR_CNT_WIDTH-1:0] ErrCntMax = {ERR_CNT_WIDTH{1'b1}};

    ctrl_state_e              state_q;
    logic [BINARY_WIDTH-1:0]  binary_q;
    logic                     err_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_d;

    logic [BINARY_WIDTH-1:0]  enc_index;
    logic                     enc_zero;
    logic                     enc_multi;
    logic                     enc_illegal;
    logic                     accept;

    one_hot_priority_enc #(
        .BINARY_WIDTH (BINARY_WIDTH)
    ) u_priority_enc (
        .one_hot_in (one_hot_in),
        .index      (enc_index),
        .zero       (enc_zero),
        .multi      (enc_multi)
    );

    // Handshake decode; in_ready looks through a draining register for full throughput.
    always_comb begin
        out_valid   = (state_q == StFull);
        in_ready    = !out_valid || out_ready;
        accept      = in_valid && in_ready;
        enc_illegal = enc_zero || enc_multi;
        binary_out  = binary_q;
        out_err     = err_q;
        err_count   = err_cnt_q;
    end

    // Output register control: load on every accept, drop to EMPTY on a bare transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StEmpty;
            binary_q <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_q  <= StFull;
                        binary_q <= enc_index;
                        err_q    <= enc_illegal;
                    end
                end
                StFull: begin
                    if (accept) begin
                        binary_q <= enc_index;
                        err_q    <= enc_illegal;
                    end else if (out_ready) begin
                        state_q <= StEmpty;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                end
            endcase
        end
    end

    // Error count next state: a clear coinciding with an illegal accept keeps that event.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clear_err) begin
            err_cnt_d = (accept && enc_illegal) ? ERR_CNT_WIDTH'(1) : '0;
        end else if (accept && enc_illegal && (err_cnt_q != ErrCntMax)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        end
    end

    // Error count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_one_hot_encoder.sv
// Bench for one_hot_encoder: directed vectors with literal expectations plus a
// queue-based reference model checked on every falling clock edge.
module tb_one_hot_encoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] one_hot_in;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] binary_out;
    logic       out_err;
    logic [7:0] err_count;
    logic       clear_err;

    int n_tests = 0;
    int n_fail  = 0;

    one_hot_encoder #(
        .BINARY_WIDTH  (2),
        .ERR_CNT_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .one_hot_in (one_hot_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .binary_out (binary_out),
        .out_err    (out_err),
        .err_count  (err_count),
        .clear_err  (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: result is {lowest set index, error} from the encoding rules.
    function automatic logic [2:0] ref_result(input logic [3:0] w);
        int idx;
        idx = 0;
        for (int i = 3; i >= 0; i--) begin
            if (w[i]) idx = i;
        end
        return {idx[1:0], ($countones(w) != 1)};
    endfunction

    logic [2:0] exp_q[$];
    int         exp_cnt = 0;

    // Model compare on every falling edge, then advance the model by what the next edge sees.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt = 0;
            check("rst_out_valid", 32'(out_valid), 32'd0);
        end else begin
            logic acc;
            logic xfer;
            logic [2:0] r;
            check("m_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("m_in_ready", 32'(in_ready), 32'((exp_q.size() == 0) || out_ready));
            check("m_err_count", 32'(err_count), 32'(exp_cnt));
            if (exp_q.size() != 0) begin
                check("m_binary_out", 32'(binary_out), 32'(exp_q[0][2:1]));
                check("m_out_err", 32'(out_err), 32'(exp_q[0][0]));
            end
            xfer = (exp_q.size() != 0) && out_ready;
            acc  = in_valid && ((exp_q.size() == 0) || out_ready);
            r    = ref_result(one_hot_in);
            if (xfer) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(r);
            if (clear_err) exp_cnt = (acc && r[0]) ? 1 : 0;
            else if (acc && r[0] && exp_cnt < 255) exp_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        one_hot_in = 4'b0;
        out_ready  = 1'b0;
        clear_err  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_binary", 32'(binary_out), 32'd0);
        check("reset_out_err", 32'(out_err), 32'd0);
        check("reset_err_count", 32'(err_count), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        step();

        // Legal sweep, back to back.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid   = 1'b1;
            one_hot_in = 4'(1 << i);
            step();
            check("sweep_valid", 32'(out_valid), 32'd1);
            check("sweep_binary", 32'(binary_out), 32'(i));
            check("sweep_err", 32'(out_err), 32'd0);
            check("sweep_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("sweep_err_count", 32'(err_count), 32'd0);

        // Illegal codes.
        in_valid   = 1'b1;
        one_hot_in = 4'b0000;
        step();
        check("zero_binary", 32'(binary_out), 32'd0);
        check("zero_err", 32'(out_err), 32'd1);
        one_hot_in = 4'b0110;
        step();
        check("multi_binary", 32'(binary_out), 32'd1);
        check("multi_err", 32'(out_err), 32'd1);
        check("illegal_count", 32'(err_count), 32'd2);
        in_valid = 1'b0;
        step();

        // Backpressure: result holds, pending illegal word neither accepted nor counted.
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        one_hot_in = 4'b0100;
        step();
        one_hot_in = 4'b0011;
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_binary", 32'(binary_out), 32'd2);
        #1;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        repeat (3) step();
        check("bp_hold_binary", 32'(binary_out), 32'd2);
        check("bp_hold_err", 32'(out_err), 32'd0);
        check("bp_hold_count", 32'(err_count), 32'd2);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_binary", 32'(binary_out), 32'd0);
        check("bp_next_err", 32'(out_err), 32'd1);
        check("bp_next_count", 32'(err_count), 32'd3);
        in_valid = 1'b0;
        step();

        // Saturation, then clear with and without a coincident illegal accept.
        in_valid   = 1'b1;
        one_hot_in = 4'b1100;
        repeat (300) step();
        check("sat_count", 32'(err_count), 32'd255);
        in_valid = 1'b0;
        step();
        check("sat_hold", 32'(err_count), 32'd255);
        clear_err  = 1'b1;
        in_valid   = 1'b1;
        one_hot_in = 4'b0000;
        step();
        check("clear_with_err", 32'(err_count), 32'd1);
        in_valid = 1'b0;
        step();
        check("clear_alone", 32'(err_count), 32'd0);
        clear_err = 1'b0;
        step();

        // Asynchronous reset while FULL and stalled.
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        one_hot_in = 4'b0000;
        step();
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_count", 32'(err_count), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_count", 32'(err_count), 32'd0);
        check("async_rst_binary", 32'(binary_out), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        one_hot_in = 4'b1000;
        step();
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_binary", 32'(binary_out), 32'd3);
        in_valid = 1'b0;
        step();

        // Random mixed stream; the model process checks every cycle.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clear_err = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 0) one_hot_in = 4'(1 << $urandom_range(0, 3));
            else one_hot_in = 4'($urandom_range(0, 15));
            step();
        end
        in_valid  = 1'b0;
        clear_err = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        check("drain_empty", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/one_hot_encoder.md
Name: one_hot_encoder

Overview:
- Registered one-hot to binary encoder; inverse of the team's one-hot decoder.
- Accepts one-hot words on a valid/ready handshake and emits the binary index one cycle later.
- Flags illegal codes (zero-hot, multi-hot) and keeps a saturating error count.
- Sits at the boundary where one-hot grant/select vectors are converted back to indices for downstream datapaths.

Parameters:
- BINARY_WIDTH, 2, width of binary index output; must be >= 1.
- ONE_HOT_WIDTH, 1 << BINARY_WIDTH, width of one-hot input; derived, never overridden.
- ERR_CNT_WIDTH, 8, width of saturating error counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  one_hot_in holds a word.
- in_ready  output  1  block can accept a word this cycle.
- one_hot_in  input  ONE_HOT_WIDTH  one-hot code; bit i set means index i.
- out_valid  output  1  binary_out/out_err hold a result.
- out_ready  input  1  downstream accepts the result.
- binary_out  output  BINARY_WIDTH  encoded index.
- out_err  output  1  result came from an illegal input code.
- err_count  output  ERR_CNT_WIDTH  number of accepted illegal words, saturating.
- clear_err  input  1  synchronous clear of err_count.

Behaviour:
- Reset (rst_n low, asynchronous assert, deasserted synchronously by the system): out_valid=0, binary_out=0, out_err=0, err_count=0. in_ready=1 one cycle after reset release. Reset mid-transfer discards any held result with no output pulse.
- Handshake:
  - Input accept when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational from out_ready; single output register).
  - Two-state control, EMPTY (out_valid=0) and FULL (out_valid=1):
    - EMPTY -> FULL on accept.
    - FULL -> EMPTY on transfer without accept.
    - FULL stays FULL on simultaneous transfer and accept; new result loads, giving full throughput of 1 word/cycle.
  - While FULL && !out_ready, binary_out, out_err and out_valid hold stable.
- Latency: exactly 1 cycle from accept to out_valid with the result.
- Encoding rules:
  - Exactly one bit set at position i: binary_out=i, out_err=0.
  - Zero bits set: binary_out=0, out_err=1.
  - Two or more bits set: binary_out = index of lowest set bit, out_err=1.
- err_count:
  - Increments by 1 on each accepted word with an illegal code.
  - Saturates at 2^ERR_CNT_WIDTH-1; never wraps.
  - clear_err alone: count goes to 0 next cycle.
  - clear_err together with an accepted illegal word: count goes to 1, so the event is not lost.
  - The count is not affected by output backpressure.
- one_hot_in is ignored when in_valid=0 or in_ready=0; no errors are counted for unaccepted words.

Decomposition:
- Package one_hot_pkg: the BINARY_WIDTH-to-ONE_HOT_WIDTH derivation and an enum for the EMPTY/FULL control state.
- One combinational sub-module, one_hot_priority_enc: inputs one_hot_in; outputs lowest-set-bit index, zero flag and multi-hot flag. It is reusable by arbiters.
- one_hot_encoder contains the handshake register and the error counter.

Test Plan (BINARY_WIDTH=2, ERR_CNT_WIDTH=8):
- Sweep 4'b0001, 4'b0010, 4'b0100, 4'b1000 back-to-back with out_ready=1 -> binary_out 0,1,2,3 on consecutive cycles, each 1 cycle after accept; out_err=0; err_count=0; in_ready never drops.
- Illegal codes 4'b0000, then 4'b0110 -> binary_out=0, out_err=1, then binary_out=1, out_err=1; err_count=2.
- Hold out_ready=0 after accepting 4'b0100 -> out_valid=1, binary_out=2 stable; in_ready=0; new in_valid words are not accepted. Raise out_ready -> transfer, and the pending input is accepted in the same cycle.
- Send 300 words of 4'b1100 -> err_count saturates at 255 and stays there. Then clear_err in the same cycle as an accepted 4'b0000 -> err_count=1.
- Assert rst_n=0 while FULL with out_ready=0 -> out_valid=0, err_count=0 immediately, without waiting for a clock edge. After release, the first accepted 4'b1000 -> binary_out=3.
- Random legal/illegal stream with random out_ready -> every output matches the reference model in order, with no drops or duplicates.
